// File: rtl/uart_msg_receiver.sv
// Assembles terminator-delimited messages from a UART RX byte stream and
// holds each complete message until the consumer acknowledges it.
module uart_msg_receiver #(
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [7:0]  TERM_CHAR = 8'h0D,
    localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    input  logic                 rx_err,
    input  logic                 msg_ack,
    output logic                 msg_valid,
    output logic [LEN_W-1:0]     msg_len,
    output logic [8*MAX_LEN-1:0] msg_data,
    output logic                 msg_dropped,
    output logic                 rx_lost
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 valid_q, valid_d;
    logic                 dropped_q, dropped_d;
    logic                 lost_q, lost_d;

    logic byte_v;
    logic is_term;

    // An error strobe masks a byte arriving in the same cycle.
    assign byte_v  = rx_valid & ~rx_err;
    assign is_term = (rx_data == TERM_CHAR);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_d     = buf_q;
        len_d     = len_q;
        valid_d   = valid_q;
        dropped_d = 1'b0;
        lost_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (byte_v && !is_term) begin
                    buf_d       = '0;
                    buf_d[7:0]  = rx_data;
                    count_d     = LEN_W'(1);
                    state_d     = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (rx_err) begin
                    state_d = ST_DISCARD;
                end else if (rx_valid) begin
                    if (is_term) begin
                        len_d   = count_q;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (count_q == LEN_W'(MAX_LEN)) begin
                        state_d = ST_DISCARD;
                    end else begin
                        for (int i = 0; i < int'(MAX_LEN); i++) begin
                            if (count_q == LEN_W'(i)) begin
                                buf_d[8*i +: 8] = rx_data;
                            end
                        end
                        count_d = count_q + LEN_W'(1);
                    end
                end
            end
            ST_DISCARD: begin
                if (byte_v && is_term) begin
                    dropped_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                if (byte_v) begin
                    lost_d = 1'b1;
                end
                if (msg_ack) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            buf_q     <= '0;
            len_q     <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            len_q     <= len_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
            lost_q    <= lost_d;
        end
    end

    assign msg_valid   = valid_q;
    assign msg_len     = len_q;
    assign msg_data    = buf_q;
    assign msg_dropped = dropped_q;
    assign rx_lost     = lost_q;

endmodule

// File: tb/tb_uart_msg_receiver.sv
// Self-checking bench for uart_msg_receiver: directed scenarios followed by
// random traffic, all compared against a queue-based message model.
module tb_uart_msg_receiver;

    localparam int unsigned MAXL  = 4;
    localparam logic [7:0]  TERM  = 8'h0D;
    localparam int unsigned LW    = $clog2(MAXL + 1);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_err;
    logic            msg_ack;
    logic            msg_valid;
    logic [LW-1:0]   msg_len;
    logic [8*MAXL-1:0] msg_data;
    logic            msg_dropped;
    logic            rx_lost;

    int n_cmp = 0;
    int n_err = 0;

    // Model: bytes of the message under assembly plus what is on display.
    logic [7:0]        m_q[$];
    bit                m_collecting, m_discarding, m_pending;
    int                m_len;
    logic [8*MAXL-1:0] m_data;
    bit                m_dropped, m_lost;

    uart_msg_receiver #(.MAX_LEN(MAXL), .TERM_CHAR(TERM)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .msg_ack(msg_ack), .msg_valid(msg_valid),
        .msg_len(msg_len), .msg_data(msg_data), .msg_dropped(msg_dropped),
        .rx_lost(rx_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_collecting = 0; m_discarding = 0; m_pending = 0;
        m_len = 0; m_data = '0; m_dropped = 0; m_lost = 0;
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] d, input bit e, input bit a);
        bit got;
        got = v && !e;
        m_dropped = 0;
        m_lost = 0;
        if (m_pending) begin
            if (got) m_lost = 1;
            if (a) m_pending = 0;
        end else if (m_discarding) begin
            if (got && d == TERM) begin
                m_dropped = 1;
                m_discarding = 0;
            end
        end else if (m_collecting) begin
            if (e) begin
                m_collecting = 0; m_discarding = 1;
            end else if (got && d == TERM) begin
                m_len = m_q.size();
                m_collecting = 0; m_pending = 1;
            end else if (got && m_q.size() == MAXL) begin
                m_collecting = 0; m_discarding = 1;
            end else if (got) begin
                m_data[8*m_q.size() +: 8] = d;
                m_q.push_back(d);
            end
        end else if (got && d != TERM) begin
            m_q.delete();
            m_q.push_back(d);
            m_data = '0;
            m_data[7:0] = d;
            m_collecting = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   64'(msg_valid),   64'(m_pending));
        chk({tag, ".len"},     64'(msg_len),     64'(m_len));
        chk({tag, ".data"},    64'(msg_data),    64'(m_data));
        chk({tag, ".dropped"}, 64'(msg_dropped), 64'(m_dropped));
        chk({tag, ".lost"},    64'(rx_lost),     64'(m_lost));
    endtask

    // One clock: drive inputs, update model at the edge, compare 1 ns later.
    task automatic step(input string tag, input bit v, input logic [7:0] d, input bit e, input bit a);
        rx_valid = v; rx_data = d; rx_err = e; msg_ack = a;
        @(posedge clk);
        model_cycle(v, d, e, a);
        #1;
        check_all(tag);
        rx_valid = 0; rx_data = 8'h00; rx_err = 0; msg_ack = 0;
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        step(tag, 1'b1, d, 1'b0, 1'b0);
    endtask

    initial begin
        bit rv, re, ra;
        logic [7:0] rd;
        rst_n = 0; rx_valid = 0; rx_data = 8'h00; rx_err = 0; msg_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_all("reset");
        rst_n = 1;

        // Basic message
        send("basic", 8'h41); send("basic", 8'h42); send("basic", TERM);
        chk("basic.valid_c", 64'(msg_valid), 64'd1);
        chk("basic.len_c", 64'(msg_len), 64'd2);
        chk("basic.data_c", 64'(msg_data), 64'h0000_4241);
        step("basic.ack", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("basic.ack_c", 64'(msg_valid), 64'd0);

        // Length boundary
        send("full", 8'h57); send("full", 8'h58); send("full", 8'h59);
        send("full", 8'h5A); send("full", TERM);
        chk("full.len_c", 64'(msg_len), 64'd4);
        chk("full.data_c", 64'(msg_data), 64'h5A59_5857);
        step("full.ack", 1'b0, 8'h00, 1'b0, 1'b1);

        // Overflow
        for (int i = 0; i < 5; i++) send("ovf", 8'h41 + 8'(i));
        chk("ovf.valid_c", 64'(msg_valid), 64'd0);
        send("ovf.term", TERM);
        chk("ovf.dropped_c", 64'(msg_dropped), 64'd1);
        step("ovf.after", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf.once_c", 64'(msg_dropped), 64'd0);
        send("ovf.next", 8'h31); send("ovf.next", TERM);
        chk("ovf.len_c", 64'(msg_len), 64'd1);
        chk("ovf.data_c", 64'(msg_data), 64'h0000_0031);
        step("ovf.ack", 1'b0, 8'h00, 1'b0, 1'b1);

        // Error then empty
        send("err", 8'h41);
        step("err.strobe", 1'b0, 8'h00, 1'b1, 1'b0);
        send("err", 8'h42); send("err.term", TERM);
        chk("err.dropped_c", 64'(msg_dropped), 64'd1);
        chk("err.valid_c", 64'(msg_valid), 64'd0);
        send("empty", TERM);
        step("empty", 1'b0, 8'h00, 1'b0, 1'b0);

        // Pending message and ack with simultaneous byte
        send("pend", 8'h41); send("pend", TERM);
        send("pend.lost", 8'h42);
        chk("pend.lost_c", 64'(rx_lost), 64'd1);
        chk("pend.data_c", 64'(msg_data), 64'h0000_0041);
        step("pend.ackbyte", 1'b1, 8'h43, 1'b0, 1'b1);
        chk("pend.ackbyte_c", 64'(rx_lost), 64'd1);
        step("pend.idle", 1'b0, 8'h00, 1'b0, 1'b0);
        send("pend.new", 8'h44); send("pend.new", TERM);
        chk("pend.new_c", 64'(msg_data), 64'h0000_0044);
        step("pend.ack2", 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset mid-message
        send("rst", 8'h41); send("rst", 8'h42);
        #3 rst_n = 0;
        #1;
        model_reset();
        check_all("rst.async");
        #2 rst_n = 1;
        send("rst.next", 8'h43); send("rst.next", TERM);
        chk("rst.len_c", 64'(msg_len), 64'd1);
        chk("rst.data_c", 64'(msg_data), 64'h0000_0043);
        step("rst.ack", 1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rv = ($urandom % 3) != 0;
            rd = (($urandom % 4) == 0) ? TERM : 8'($urandom);
            re = ($urandom % 25) == 0;
            ra = ($urandom % 4) == 0;
            step("rand", rv, rd, re, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_msg_receiver.md
# uart_msg_receiver

Receive-side message assembler for the UART interface. It collects bytes from the UART receiver into a message buffer until a terminator byte arrives, then presents the complete message and its length to the consumer and holds it until acknowledged. It is the inbound counterpart of the message transmit FSM: it sits between the UART RX byte interface and the command/consumer logic.

## Interface
- `MAX_LEN`, default 16: maximum payload bytes per message, excluding the terminator.
- `TERM_CHAR`, default 8'h0D: terminator byte. It is never stored.
- `LEN_W`, localparam, equal to $clog2(MAX_LEN+1): width of `msg_len`.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `rx_data`  in  8  received byte.
- `rx_err`  in  1  one-cycle framing/parity error strobe from the UART RX.
- `msg_ack`  in  1  consumer has taken the message.
- `msg_valid`  out  1  complete message available; level signal.
- `msg_len`  out  LEN_W  payload length, 1..MAX_LEN.
- `msg_data`  out  8*MAX_LEN  payload; byte i is at [8*i+7:8*i]; bytes at index >= `msg_len` read 0.
- `msg_dropped`  out  1  one-cycle pulse when an overflowed or errored message is discarded.
- `rx_lost`  out  1  one-cycle pulse when a byte arrives while a message is pending.

## Operation
States: IDLE, COLLECT, DISCARD, DONE. Reset enters IDLE.
- When `rx_err` and `rx_valid` occur in the same cycle, `rx_err` has priority and the byte is ignored.
- **IDLE**
  - `rx_valid` with `TERM_CHAR`: ignored; empty messages produce no output.
  - `rx_valid` with any other byte: store it at index 0, zero all other buffer bytes, set count to 1, go to COLLECT.
  - `rx_err`: ignored.
- **COLLECT**
  - `rx_valid` with a non-terminator byte and count < MAX_LEN: store it at index count, count++.
  - `rx_valid` with a non-terminator byte and count == MAX_LEN: go to DISCARD (overflow).
  - `rx_valid` with `TERM_CHAR`: `msg_len` <= count, go to DONE.
  - `rx_err`: go to DISCARD.
- **DISCARD**
  - Drops all bytes.
  - On `rx_valid` with `TERM_CHAR`: pulse `msg_dropped`, go to IDLE.
  - `rx_err` is ignored.
- **DONE**
  - `msg_valid` = 1; `msg_data` and `msg_len` are stable.
  - Any `rx_valid`, including a terminator: byte dropped, `rx_lost` pulses.
  - `msg_ack`: go to IDLE. If `rx_valid` occurs in the same cycle, that byte is still dropped and `rx_lost` still pulses.
- `msg_ack` outside DONE is ignored.
- Count is LEN_W bits wide and never exceeds MAX_LEN; there is no wrap-around.
- `msg_data` and `msg_len` hold their last values after ack until the next message's first byte overwrites and zero-fills the buffer.

## Timing
- All outputs are registered.
- Reset values: `msg_valid`=0, `msg_len`=0, `msg_data`=0, `msg_dropped`=0, `rx_lost`=0, state=IDLE, count=0.
- Reset asserted mid-message forces IDLE immediately. The partial message is lost and no `msg_dropped` pulse is generated.
- Terminator sampled on edge N: `msg_valid`=1 from edge N onward (visible in cycle N+1), i.e. 1-cycle latency.
- `msg_ack` sampled on edge M: `msg_valid`=0 after edge M. A new message can start from the byte sampled on edge M+1.
- `msg_dropped` and `rx_lost` are high for exactly one cycle per event.
- Back-to-back `rx_valid` on consecutive cycles is supported in every state.

## Test plan
Configuration: MAX_LEN=4, TERM_CHAR=8'h0D.
- Basic message: send 0x41, 0x42, 0x0D -> `msg_valid`=1 one cycle after the 0x0D; `msg_len`=2; `msg_data`=32'h0000_4241. Assert `msg_ack` -> `msg_valid`=0 next cycle.
- Length boundary: send 0x57, 0x58, 0x59, 0x5A, 0x0D -> `msg_len`=4, `msg_data`=32'h5A59_5857.
- Overflow: send 0x41..0x45 (5 bytes), then 0x0D -> `msg_valid` stays 0 and `msg_dropped` pulses once, on the 0x0D. Then send 0x31, 0x0D -> `msg_len`=1, `msg_data`=32'h0000_0031.
- Error and empty: send 0x41, then an `rx_err` strobe, then 0x42, 0x0D -> one `msg_dropped` pulse, no `msg_valid`. A lone 0x0D in IDLE -> no output activity.
- Pending message: complete 0x41, 0x0D; send 0x42 while DONE -> `rx_lost` pulses and `msg_data` is unchanged. Assert `msg_ack` and `rx_valid` in the same cycle -> that byte is dropped with `rx_lost`, and the state is IDLE.
- Reset: after 0x41, 0x42 in COLLECT, pulse `rst_n` low asynchronously (mid-cycle) -> all outputs are 0 immediately. Then 0x43, 0x0D -> `msg_len`=1, `msg_data`=32'h0000_0043.
